// File: rtl/log_arb_pkg.sv
// rtl/log_arb_pkg.sv - shared types and constants for the log-multiplier arbiter
package log_arb_pkg;

    localparam int STAT_W   = 16;
    localparam int TAG_ID_W = 3;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tag id is sized for the largest supported requester count (8).
    typedef struct packed {
        logic                valid;
        logic                zero;
        logic [TAG_ID_W-1:0] id;
    } log_tag_t;

endpackage

// File: rtl/log_mult_arbiter_rr.sv
// rtl/log_mult_arbiter_rr.sv - combinational round-robin grant from a rotating pointer
module rr_arbiter
    import log_arb_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W-1:0] cand;

    // Scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        if (enable) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = ID_W'((int'(ptr) + k) % NUM_REQ);
                if (req[cand]) begin
                    grant_idx   = cand;
                    grant_valid = 1'b1;
                end
            end
        end
        if (grant_valid) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/log_mult_arbiter.sv
// rtl/log_mult_arbiter.sv - round-robin sharing of a pipelined log multiplier; LOG_ARB_STATS_EN adds counters
module log_mult_arbiter
    import log_arb_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  DATA_W   = 8,
    parameter int  CORE_LAT = 2,
    localparam int ID_W     = id_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      core_valid,
    output logic [DATA_W-1:0]         core_a,
    output logic [DATA_W-1:0]         core_b,
    input  logic [2*DATA_W-1:0]       core_result,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [2*DATA_W-1:0]       rsp_data
`ifdef LOG_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_grants,
    output logic [STAT_W-1:0]         stat_zero_bypass
`endif
);

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_idx;
    logic              fire;
    logic [DATA_W-1:0] a_arr [NUM_REQ];
    logic [DATA_W-1:0] b_arr [NUM_REQ];
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic              zero;
    log_tag_t          tag_pipe [CORE_LAT+1];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*DATA_W +: DATA_W];
        assign b_arr[g] = req_b[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req         (req_valid),
        .enable      (enable && !reset),
        .ptr         (ptr),
        .grant       (req_ready),
        .grant_idx   (grant_idx),
        .grant_valid (fire)
    );

    assign sel_a = a_arr[grant_idx];
    assign sel_b = b_arr[grant_idx];
    assign zero  = (sel_a == '0) || (sel_b == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            core_valid <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            for (int i = 0; i <= CORE_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            core_valid <= fire && !zero;
            if (fire) begin
                ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            // Zero-bypassed ops leave the core operands untouched.
            if (fire && !zero) begin
                core_a <= sel_a;
                core_b <= sel_b;
            end
            tag_pipe[0] <= '{valid: fire, zero: zero, id: TAG_ID_W'(grant_idx)};
            for (int i = 1; i <= CORE_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            rsp_valid <= tag_pipe[CORE_LAT].valid;
            if (tag_pipe[CORE_LAT].valid) begin
                rsp_id   <= tag_pipe[CORE_LAT].id[ID_W-1:0];
                rsp_data <= tag_pipe[CORE_LAT].zero ? '0 : core_result;
            end
        end
    end

`ifdef LOG_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt [NUM_REQ];
    logic [STAT_W-1:0] zero_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
            end
            zero_cnt <= '0;
        end else if (fire) begin
            if (grant_cnt[grant_idx] != '1) begin
                grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 1'b1;
            end
            if (zero && zero_cnt != '1) begin
                zero_cnt <= zero_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign stat_grants[g*STAT_W +: STAT_W] = grant_cnt[g];
    end
    assign stat_zero_bypass = zero_cnt;
`endif

endmodule

// File: tb/tb_log_mult_arbiter.sv
// tb/tb_log_mult_arbiter.sv - directed scoreboard bench for log_mult_arbiter with a Mitchell core model
module tb_log_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        core_valid;
    logic [7:0]  core_a;
    logic [7:0]  core_b;
    logic [15:0] core_result;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
`ifdef LOG_ARB_STATS_EN
    logic [63:0] stat_grants;
    logic [15:0] stat_zero_bypass;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    logic [7:0] opa [4];
    logic [7:0] opb [4];

    log_mult_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .core_valid  (core_valid),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_result (core_result),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data)
`ifdef LOG_ARB_STATS_EN
        ,
        .stat_grants      (stat_grants),
        .stat_zero_bypass (stat_zero_bypass)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mitchell(input logic [7:0] a, input logic [7:0] b);
        int ka, kb, fa, fb, s;
        if (a == 8'd0 || b == 8'd0) return 16'd0;
        ka = 0;
        kb = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i]) ka = i;
            if (b[i]) kb = i;
        end
        fa = (int'(a) << (8 - ka)) - 256;
        fb = (int'(b) << (8 - kb)) - 256;
        s  = fa + fb;
        if (s < 256) return 16'(((256 + s) << (ka + kb)) >> 8);
        return 16'((s << (ka + kb + 1)) >> 8);
    endfunction

    // Behavioural core, latency 2, unaware of the arbiter's reset.
    logic [15:0] core_s1, core_s2;
    always @(posedge clk) begin
        core_s1 <= mitchell(core_a, core_b);
        core_s2 <= core_s1;
    end
    assign core_result = core_s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input logic [3:0] exp_ready, input int id,
                                input logic [15:0] data);
        check(tag, 32'(req_ready), 32'(exp_ready));
        sb.push_back('{cyc: cyc + 4, id: id, data: data});
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]     = 1'b1;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("rsp_cycle", cyc, e.cyc);
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        req_valid = 4'hF;
        req_a     = 32'h0102_0304;
        req_b     = 32'h0506_0708;
        repeat (2) @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_core_valid", 32'(core_valid), 32'h0);
        check("reset_core_a", 32'(core_a), 32'h0);
        check("reset_core_b", 32'(core_b), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_id", 32'(rsp_id), 32'h0);
        check("reset_rsp_data", 32'(rsp_data), 32'h0);
        req_valid = '0;
        reset     = 1'b0;

        // single op
        @(negedge clk);
        set_req(0, 8'd3, 8'd5);
        #1 expect_grant("single_ready", 4'b0001, 0, 16'd14);
        @(negedge clk);
        req_valid = '0;
        check("single_core_valid", 32'(core_valid), 32'h1);
        check("single_core_a", 32'(core_a), 32'd3);
        check("single_core_b", 32'(core_b), 32'd5);
        idle(6);

        // saturating load from a fresh pointer
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            opa[i] = 8'($urandom_range(1, 255));
            opb[i] = 8'($urandom_range(1, 255));
        end
        opa[0] = 8'd3;
        opb[0] = 8'd3;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) set_req(i, opa[i], opb[i]);
            #1 expect_grant("sat_ready", 4'(1 << (k % 4)), k % 4, mitchell(opa[k % 4], opb[k % 4]));
            opa[k % 4] = 8'($urandom_range(1, 255));
            opb[k % 4] = 8'($urandom_range(1, 255));
        end
        @(negedge clk);
        req_valid = '0;

        // zero bypass with a nonzero neighbour
        @(negedge clk);
        set_req(2, 8'd0, 8'd200);
        #1 expect_grant("zero_ready", 4'b0100, 2, 16'h0000);
        @(negedge clk);
        req_valid = '0;
        set_req(3, 8'd7, 8'd9);
        #1 check("zero_core_valid", 32'(core_valid), 32'h0);
        expect_grant("neigh_ready", 4'b1000, 3, mitchell(8'd7, 8'd9));
        @(negedge clk);
        req_valid = '0;
        check("neigh_core_valid", 32'(core_valid), 32'h1);
        check("neigh_core_a", 32'(core_a), 32'd7);
        idle(6);
`ifdef LOG_ARB_STATS_EN
        check("stat_grants0", 32'(stat_grants[15:0]), 32'd2);
        check("stat_grants2", 32'(stat_grants[47:32]), 32'd3);
        check("stat_grants3", 32'(stat_grants[63:48]), 32'd3);
        check("stat_zero", 32'(stat_zero_bypass), 32'd1);
`endif

        // enable gating, pointer left at 2
        @(negedge clk);
        set_req(1, 8'd10, 8'd11);
        #1 expect_grant("gate_pre_ready", 4'b0010, 1, mitchell(8'd10, 8'd11));
        @(negedge clk);
        enable = 1'b0;
        set_req(1, 8'd20, 8'd30);
        set_req(3, 8'd255, 8'd255);
        for (int k = 0; k < 5; k++) begin
            #1 check("gate_off_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        enable = 1'b1;
        #1 expect_grant("gate_on_ready3", 4'b1000, 3, mitchell(8'd255, 8'd255));
        @(negedge clk);
        req_valid[3] = 1'b0;
        #1 expect_grant("gate_on_ready1", 4'b0010, 1, mitchell(8'd20, 8'd30));
        @(negedge clk);
        idle(6);

        // reset with three ops in flight
        @(negedge clk);
        set_req(0, 8'd5, 8'd6);
        #1 check("flight_ready0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        set_req(1, 8'd7, 8'd8);
        #1 check("flight_ready1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        set_req(2, 8'd9, 8'd10);
        #1 check("flight_ready2", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = '0;
        reset     = 1'b1;
        @(negedge clk);
        check("flight_core_valid", 32'(core_valid), 32'h0);
        check("flight_core_a", 32'(core_a), 32'h0);
        check("flight_rsp_valid", 32'(rsp_valid), 32'h0);
        check("flight_rsp_data", 32'(rsp_data), 32'h0);
`ifdef LOG_ARB_STATS_EN
        check("stat_clear", 32'(stat_grants[31:0]) | 32'(stat_zero_bypass), 32'h0);
`endif
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) set_req(i, 8'd12, 8'd13);
        #1 expect_grant("post_reset_ptr", 4'b0001, 0, mitchell(8'd12, 8'd13));
        @(negedge clk);
        idle(8);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
